touch_iic_seq: RTL
==================

Name: touch_iic_seq

Overview:
- Sequencer that drives the shared byte-level I2C master (iic_dri) to service the capacitive touch panel (GT911-class, on lcd_scl/lcd_sda/lcd_int).
- Performs the power-up clear, then on each touch interrupt reads the status register and the first touch point, clears the status register, and presents clamped X/Y coordinates to the display logic.
- Sits between iic_dri and the LCD/overlay logic in top. Runs on the 50 MHz system clock.

Parameters:
- DEV_ADDR, 7'h5D, 7-bit touch controller I2C address.
- STAT_REG, 16'h814E, status register (bit7 = buffer ready, bits3:0 = point count).
- PT_REG, 16'h8150, first point register (XL, XH, YL, YH at +0..+3).
- INIT_DLY, 5_000_000, cycles from reset release to first transaction (100 ms).
- RETRY_DLY, 50_000, back-off cycles after a NACK (1 ms).
- POLL_PERIOD, 500_000, poll interval in cycles (10 ms), used only with TOUCH_POLL_EN.
- MAX_X, 800, horizontal resolution; X is clamped to MAX_X-1.
- MAX_Y, 480, vertical resolution; Y is clamped to MAX_Y-1.

Ports:
- clk  in  1  50 MHz system clock
- rstn  in  1  asynchronous active-low reset
- lcd_int  in  1  touch interrupt, asynchronous, rising edge = new data
- iic_req  out  1  transaction request to iic_dri
- iic_rw  out  1  0 = write, 1 = read
- iic_dev_addr  out  7  device address
- iic_reg_addr  out  16  register address
- iic_wdata  out  8  write byte
- iic_done  in  1  one-cycle pulse: transaction finished
- iic_err  in  1  NACK flag, valid with iic_done
- iic_rdata  in  8  read byte, valid with iic_done
- touch_x  out  12  clamped X coordinate
- touch_y  out  12  clamped Y coordinate
- touch_num  out  4  last valid point count
- touch_down  out  1  level: at least one finger present
- touch_valid  out  1  one-cycle pulse: new X/Y presented
- err_cnt  out  8  saturating NACK counter

Behaviour:
- Reset: all outputs are 0 and the state is WAIT_INIT. Reset is asynchronous; iic_req drops immediately, including mid-transaction.
- lcd_int passes through a 2-FF synchronizer, then a rising-edge detector. A detected edge sets int_pend.
- Handshake:
  - iic_req is asserted with rw/addr/wdata stable and held until the iic_done pulse.
  - iic_req deasserts in the cycle after iic_done.
  - At most one transaction is outstanding. There is at least 1 idle cycle between requests.
- State WAIT_INIT: count INIT_DLY, then go to CLR (init clear). int_pend edges are ignored and cleared during this state.
- State IDLE: if int_pend, clear int_pend and go to RD_STAT. Edges arriving in any other state set int_pend; multiple edges collapse to one service.
- State RD_STAT: read STAT_REG and latch the byte as stat.
  - stat[7] = 0: go to IDLE with no clear.
  - stat[7] = 1 and stat[3:0] = 0: touch_down <= 0, touch_num <= 0, go to CLR.
  - stat[7] = 1 and stat[3:0] in 1..5: go to RD_PT with idx = 0.
  - stat[7] = 1 and stat[3:0] > 5: invalid. Go to CLR; outputs are unchanged.
- State RD_PT: read PT_REG+idx for idx 0..3, storing bytes into XL/XH/YL/YH.
  - After idx = 3 completes, go to OUT.
  - X = {XH[3:0], XL} and Y = {YH[3:0], YL} (12-bit).
- State OUT (1 cycle):
  - touch_x = min(X, MAX_X-1) and touch_y = min(Y, MAX_Y-1).
  - touch_num = stat[3:0], touch_down = 1, and touch_valid pulses for this 1 cycle.
  - Then go to CLR.
- State CLR: write 8'h00 to STAT_REG, then go to IDLE.
- Any iic_done with iic_err = 1:
  - err_cnt increments, saturating at 255.
  - The in-progress point read is abandoned with no touch_valid; outputs keep their old values.
  - Go to ERR_WAIT.
- ERR_WAIT: count RETRY_DLY. Then go to CLR if the failed transaction came from WAIT_INIT/CLR, else go to IDLE with int_pend = 1 (retry the read once per back-off).
- Latency: with an iic_dri per-transaction time T, from edge to touch_valid is 3 sync/edge cycles + 5 transactions + the OUT cycle.

Optional Feature:
- Macro TOUCH_POLL_EN.
- Defined: a free-running POLL_PERIOD counter sets int_pend on wrap, in addition to lcd_int edges. This is for panels without a wired INT. The counter restarts from 0 after every serviced RD_STAT.
- Undefined: no poll counter. Only lcd_int edges trigger reads.

Test Plan:
- Reset release with a stub iic_dri acking in 20 cycles and INIT_DLY = 100 -> first request at cycle 100 with rw=0, reg=16'h814E, wdata=00; then IDLE, no touch_valid.
- lcd_int rise with stub returning stat=8'h81 and bytes 2C,01,F0,00 -> reads 814E, 8150..8153, then writes 814E=00; touch_valid 1 cycle with x=300, y=240, num=1, touch_down=1.
- Stub returning X=0x3FF, Y=0x2FF -> touch_x=799, touch_y=479 (clamped).
- stat=8'h80 after a prior touch -> touch_down=0, touch_num=0, CLR write issued, no touch_valid; stat=8'h00 -> no CLR write.
- iic_err on the second point read -> err_cnt=1, no touch_valid, a RETRY_DLY gap, then the full read sequence reruns. Three lcd_int edges during one sequence -> exactly one extra service.
- rstn pulled low mid RD_PT -> iic_req=0 and all outputs 0 immediately; after release, WAIT_INIT reruns.

Source files
------------

// File: rtl/touch_iic_if.sv
// touch_iic_if: byte-level request/done channel between the
// touch sequencer (master) and the shared iic_dri engine (slave).
interface touch_iic_if;
  logic        req;
  logic        rw;
  logic [6:0]  dev_addr;
  logic [15:0] reg_addr;
  logic [7:0]  wdata;
  logic        done;
  logic        err;
  logic [7:0]  rdata;

  modport master (
    output req, rw, dev_addr, reg_addr, wdata,
    input  done, err, rdata
  );

  modport slave (
    input  req, rw, dev_addr, reg_addr, wdata,
    output done, err, rdata
  );
endinterface

// File: rtl/touch_iic_seq.sv
// touch_iic_seq: GT911-class touch panel service sequencer on iic_dri.
// Define TOUCH_POLL_EN to add a free-running poll trigger (no INT wire).
module touch_iic_seq #(
  parameter logic [6:0]  DEV_ADDR    = 7'h5D,
  parameter logic [15:0] STAT_REG    = 16'h814E,
  parameter logic [15:0] PT_REG      = 16'h8150,
  parameter int          INIT_DLY    = 5_000_000,
  parameter int          RETRY_DLY   = 50_000,
  parameter int          POLL_PERIOD = 500_000,
  parameter int          MAX_X       = 800,
  parameter int          MAX_Y       = 480
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        lcd_int,
  touch_iic_if.master iic,
  output logic [11:0] touch_x,
  output logic [11:0] touch_y,
  output logic [3:0]  touch_num,
  output logic        touch_down,
  output logic        touch_valid,
  output logic [7:0]  err_cnt
);

  typedef enum logic [2:0] {
    WAIT_INIT,
    IDLE,
    RD_STAT,
    RD_PT,
    OUT,
    CLR,
    ERR_WAIT
  } state_t;

  localparam logic [11:0] X_LIM = 12'(MAX_X - 1);
  localparam logic [11:0] Y_LIM = 12'(MAX_Y - 1);
  localparam logic [31:0] INIT_END = 32'(INIT_DLY - 1);
  localparam logic [31:0] RETRY_END = 32'(RETRY_DLY - 1);

  state_t      state;
  logic [31:0] cnt;
  logic [2:0]  int_sync;
  logic        int_pend;
  logic [7:0]  stat;
  logic [7:0]  pt [4];
  logic [1:0]  idx;
  logic        err_from_clr;

  logic        int_edge;
  logic        poll_hit;
  logic        trig;
  logic        xfer_end;
  logic        stat_ok;
  logic        in_xfer;
  logic        launch;
  logic        nxt_rw;
  logic [15:0] nxt_reg;
  logic [11:0] x_raw;
  logic [11:0] y_raw;

  assign int_edge = int_sync[1] & ~int_sync[2];
  assign trig     = int_edge | poll_hit;
  assign xfer_end = iic.req & iic.done;
  assign stat_ok  = (state == RD_STAT) & xfer_end & ~iic.err;
  assign in_xfer  = (state == RD_STAT) | (state == RD_PT) | (state == CLR);
  assign launch   = (in_xfer & ~iic.req)
                  | ((state == WAIT_INIT) & (cnt == INIT_END));
  assign x_raw    = {pt[1][3:0], pt[0]};
  assign y_raw    = {pt[3][3:0], pt[2]};

  // Request fields for the transaction the current state will launch.
  always_comb begin
    nxt_rw  = 1'b1;
    nxt_reg = STAT_REG;
    if (state == RD_PT) begin
      nxt_reg = PT_REG + 16'(idx);
    end else if (state == CLR || state == WAIT_INIT) begin
      nxt_rw = 1'b0;
    end
  end

  // Two-stage synchronizer plus one history bit for edge detection.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) int_sync <= '0;
    else       int_sync <= {int_sync[1:0], lcd_int};
  end

`ifdef TOUCH_POLL_EN
  logic [31:0] poll_cnt;

  assign poll_hit = (poll_cnt == 32'(POLL_PERIOD - 1));

  // Poll timer: wraps to raise a read, restarts after each status read.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                   poll_cnt <= '0;
    else if (stat_ok || poll_hit) poll_cnt <= '0;
    else                         poll_cnt <= poll_cnt + 32'd1;
  end
`else
  logic unused_poll;

  assign unused_poll = ^32'(POLL_PERIOD);
  assign poll_hit    = 1'b0;
`endif

  // Service FSM: I2C handshake, result decode and output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= WAIT_INIT;
      cnt          <= '0;
      int_pend     <= 1'b0;
      stat         <= '0;
      pt           <= '{default: '0};
      idx          <= '0;
      err_from_clr <= 1'b0;
      iic.req      <= 1'b0;
      iic.rw       <= 1'b0;
      iic.dev_addr <= '0;
      iic.reg_addr <= '0;
      iic.wdata    <= '0;
      touch_x      <= '0;
      touch_y      <= '0;
      touch_num    <= '0;
      touch_down   <= 1'b0;
      touch_valid  <= 1'b0;
      err_cnt      <= '0;
    end else begin
      touch_valid <= 1'b0;

      if (state == WAIT_INIT) int_pend <= 1'b0;
      else if (trig)          int_pend <= 1'b1;

      if (launch) begin
        iic.req      <= 1'b1;
        iic.rw       <= nxt_rw;
        iic.dev_addr <= DEV_ADDR;
        iic.reg_addr <= nxt_reg;
        iic.wdata    <= 8'h00;
      end else if (xfer_end) begin
        iic.req <= 1'b0;
      end

      if (xfer_end && iic.err) begin
        if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
        err_from_clr <= (state == CLR);
        cnt          <= '0;
        state        <= ERR_WAIT;
      end else begin
        unique case (state)
          WAIT_INIT: begin
            if (cnt == INIT_END) begin
              cnt   <= '0;
              state <= CLR;
            end else begin
              cnt <= cnt + 32'd1;
            end
          end
          IDLE: begin
            if (int_pend) begin
              int_pend <= trig;
              state    <= RD_STAT;
            end
          end
          RD_STAT: begin
            if (xfer_end) begin
              stat <= iic.rdata;
              if (!iic.rdata[7]) begin
                state <= IDLE;
              end else if (iic.rdata[3:0] == 4'd0) begin
                touch_down <= 1'b0;
                touch_num  <= 4'd0;
                state      <= CLR;
              end else if (iic.rdata[3:0] <= 4'd5) begin
                idx   <= 2'd0;
                state <= RD_PT;
              end else begin
                state <= CLR;
              end
            end
          end
          RD_PT: begin
            if (xfer_end) begin
              pt[idx] <= iic.rdata;
              if (idx == 2'd3) state <= OUT;
              else             idx   <= idx + 2'd1;
            end
          end
          OUT: begin
            touch_x     <= (x_raw > X_LIM) ? X_LIM : x_raw;
            touch_y     <= (y_raw > Y_LIM) ? Y_LIM : y_raw;
            touch_num   <= stat[3:0];
            touch_down  <= 1'b1;
            touch_valid <= 1'b1;
            state       <= CLR;
          end
          CLR: begin
            if (xfer_end) state <= IDLE;
          end
          ERR_WAIT: begin
            if (cnt == RETRY_END) begin
              cnt <= '0;
              if (err_from_clr) begin
                state <= CLR;
              end else begin
                int_pend <= 1'b1;
                state    <= IDLE;
              end
            end else begin
              cnt <= cnt + 32'd1;
            end
          end
          default: state <= WAIT_INIT;
        endcase
      end
    end
  end

endmodule
